// File: rtl/ascan_frame_sched.sv
// ascan_frame_sched: on each accepted sync, interleaves enabled A-scan packer streams into one 32-bit header+payload stream.
// Latency: the first header is visible the cycle after the accepted sync; payload is a combinational pass-through of the selected channel.
// Backpressure: i_out_rdy drives only the selected channel's o_ch_rdy; output is held while o_out_vld & ~i_out_rdy; stalls wait forever.
module ascan_frame_sched #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_sync,
    input  logic [N-1:0]    i_ch_en,
    input  logic [15:0]     i_words,
    output logic            o_ch_sync,
    input  logic [N*32-1:0] i_ch_data,
    input  logic [N-1:0]    i_ch_vld,
    output logic [N-1:0]    o_ch_rdy,
    output logic [31:0]     o_out_data,
    output logic            o_out_vld,
    input  logic            i_out_rdy,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Header as it appears on the wire: magic byte in the lowest byte, words
    // field byte-swapped into the top half.
    typedef struct packed {
        logic [7:0] words_lo;
        logic [7:0] words_hi;
        logic [3:0] seq;
        logic [3:0] ch;
        logic [7:0] magic;
    } hdr_t;

    logic [1:0]   state;
    logic [3:0]   seq;
    logic [N-1:0] mask;
    logic [15:0]  words;
    logic [3:0]   ch;
    logic [15:0]  cnt;

    logic [3:0]   first_ch;
    logic         first_vld;
    logic [3:0]   next_ch;
    logic         next_vld;
    logic [31:0]  sel_data;
    logic         sel_vld;
    logic [3:0]   hdr_ch;
    hdr_t         hdr;

    // Lowest enabled channel of the incoming mask, and lowest latched channel above the current one.
    always_comb begin
        first_ch  = '0;
        first_vld = 1'b0;
        next_ch   = '0;
        next_vld  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_ch_en[k]) begin
                first_ch  = 4'(k);
                first_vld = 1'b1;
            end
            if (mask[k] && (4'(k) > ch)) begin
                next_ch  = 4'(k);
                next_vld = 1'b1;
            end
        end
    end

    // Word and valid of the channel currently being drained.
    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (ch == 4'(k)) begin
                sel_data = i_ch_data[32*k +: 32];
                sel_vld  = i_ch_vld[k];
            end
        end
    end

    // Assemble the frame header; the channel field is only CW bits wide.
    always_comb begin
        hdr_ch             = '0;
        hdr_ch[CW-1:0]     = ch[CW-1:0];
        hdr.words_lo       = words[7:0];
        hdr.words_hi       = words[15:8];
        hdr.seq            = seq;
        hdr.ch             = hdr_ch;
        hdr.magic          = 8'hA5;
    end

    // Output mux: header in HDR, selected channel pass-through in DATA, quiet otherwise.
    always_comb begin
        o_out_vld  = 1'b0;
        o_out_data = '0;
        o_ch_rdy   = '0;
        case (state)
            ST_HDR: begin
                o_out_vld  = 1'b1;
                o_out_data = hdr;
            end
            ST_DATA: begin
                o_out_vld  = sel_vld;
                o_out_data = sel_data;
                for (int k = 0; k < N; k++) begin
                    o_ch_rdy[k] = (ch == 4'(k)) && i_out_rdy;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_ch_sync = i_sync && (state == ST_IDLE);
    assign o_busy    = (state != ST_IDLE);

    // Scan-cycle sequencer plus the registered done/overrun pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            seq       <= '0;
            mask      <= '0;
            words     <= '0;
            ch        <= '0;
            cnt       <= '0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_done    <= (state == ST_FIN);
            o_overrun <= i_sync && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (i_sync) begin
                        mask  <= i_ch_en;
                        words <= i_words;
                        cnt   <= '0;
                        if (first_vld) begin
                            ch    <= first_ch;
                            state <= ST_HDR;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_HDR: begin
                    if (i_out_rdy) begin
                        if (words != 16'd0) begin
                            cnt   <= '0;
                            state <= ST_DATA;
                        end else begin
                            ch    <= next_ch;
                            state <= next_vld ? ST_HDR : ST_FIN;
                        end
                    end
                end
                ST_DATA: begin
                    if (sel_vld && i_out_rdy) begin
                        cnt <= cnt + 16'd1;
                        // Last payload word goes straight to the next header, no bubble.
                        if (cnt == words - 16'd1) begin
                            ch    <= next_ch;
                            state <= next_vld ? ST_HDR : ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    seq   <= seq + 4'd1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
